// File: rtl/two_to_one_mux_if.sv
// two_to_one_mux_if -- bus bundle for the registered 2:1 selector.
//
// Signals:
//   E              enable; 1 = pass the chosen input, 0 = force output to zero
//   A, B           data inputs (A when selector=0, B when selector=1)
//   selector       source select
//   selected       muxed data
//   selected_valid high when `selected` carries enabled data
//   active_src     source currently feeding `selected` (holds while disabled)
//   switch_pulse   one-cycle pulse when the enabled source changes
//
// Flow control: there is no backpressure. selected_valid is a pure qualifier
// that marks the cycles in which `selected` carries enabled data, and the
// consumer must take the data in that same cycle.
interface two_to_one_mux_if #(
    parameter int WIDTH = 1
);
    logic             E;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             selector;
    logic [WIDTH-1:0] selected;
    logic             selected_valid;
    logic             active_src;
    logic             switch_pulse;

    // Data source side: drives the inputs and observes the outputs.
    modport master (
        output E, A, B, selector,
        input  selected, selected_valid, active_src, switch_pulse
    );

    // Selector side: consumes the inputs and produces the outputs.
    modport slave (
        input  E, A, B, selector,
        output selected, selected_valid, active_src, switch_pulse
    );
endinterface

// File: rtl/two_to_one_mux.sv
// two_to_one_mux -- registered 2:1 data selector with enable and status.
//
// Ports:
//   clk  system clock; all state updates happen on its rising edge
//   rst  asynchronous, active-high reset
//   bus  two_to_one_mux_if.slave (E, A, B, selector in;
//        selected, selected_valid, active_src, switch_pulse out)
//
// Parameters:
//   WIDTH         data width of A, B and selected
//   REGISTER_OUT  1 = selected is registered (1-cycle latency)
//                 0 = selected is combinational; the status stays registered
module two_to_one_mux #(
    parameter int WIDTH        = 1,
    parameter int REGISTER_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    two_to_one_mux_if.slave       bus
);

    logic [WIDTH-1:0] selected_d;
    logic             valid_q;
    logic             active_src_q;
    logic             active_src_d;
    logic             switch_q;
    logic             switch_d;
    logic             last_en_q;

    // The selection uses an explicit if on selector, so an X or Z on the
    // unselected input never reaches the output.
    always_comb begin
        selected_d = '0;
        if (bus.E) begin
            if (bus.selector) begin
                selected_d = bus.B;
            end else begin
                selected_d = bus.A;
            end
        end
    end

    // A switch is reported only when the output was already enabled in the
    // previous cycle. Re-enabling onto a different source does not pulse.
    always_comb begin
        active_src_d = active_src_q;
        if (bus.E) begin
            active_src_d = bus.selector;
        end
        switch_d = bus.E & last_en_q & (bus.selector != active_src_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            active_src_q <= 1'b0;
            switch_q     <= 1'b0;
            last_en_q    <= 1'b0;
        end else begin
            valid_q      <= bus.E;
            active_src_q <= active_src_d;
            switch_q     <= switch_d;
            last_en_q    <= bus.E;
        end
    end

    generate
        if (REGISTER_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] selected_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    selected_q <= '0;
                end else begin
                    selected_q <= selected_d;
                end
            end

            assign bus.selected = selected_q;
        end else begin : g_comb_out
            // The combinational path still respects reset, so the output
            // reads zero while rst is high.
            assign bus.selected = rst ? '0 : selected_d;
        end
    endgenerate

    assign bus.selected_valid = valid_q;
    assign bus.active_src     = active_src_q;
    assign bus.switch_pulse   = switch_q;

endmodule

// File: tb/tb_two_to_one_mux.sv
// tb_two_to_one_mux -- bench for two_to_one_mux.
// Two instances share the same stimulus: dut_r (WIDTH=8, REGISTER_OUT=1)
// and dut_c (WIDTH=8, REGISTER_OUT=0).
module tb_two_to_one_mux;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  logic         e_s = 1'b0;
  logic         sel_s = 1'b0;
  logic [W-1:0] a_s = '0;
  logic [W-1:0] b_s = '0;

  two_to_one_mux_if #(.WIDTH(W)) if_r ();
  two_to_one_mux_if #(.WIDTH(W)) if_c ();

  assign if_r.E = e_s;
  assign if_r.A = a_s;
  assign if_r.B = b_s;
  assign if_r.selector = sel_s;
  assign if_c.E = e_s;
  assign if_c.A = a_s;
  assign if_c.B = b_s;
  assign if_c.selector = sel_s;

  two_to_one_mux #(.WIDTH(W), .REGISTER_OUT(1)) dut_r (
    .clk (clk),
    .rst (rst_s),
    .bus (if_r)
  );

  two_to_one_mux #(.WIDTH(W), .REGISTER_OUT(0)) dut_c (
    .clk (clk),
    .rst (rst_s),
    .bus (if_c)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the list of inputs seen at each clock edge since reset
  // and derives every output from that history.
  typedef struct {
    logic         e;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } edge_t;

  edge_t hist[$];

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      hist.delete();
    end else begin
      hist.push_back('{e: e_s, sel: sel_s, a: a_s, b: b_s});
    end
  end

  function automatic logic [W-1:0] mux_now(input logic r, input logic e, input logic s,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (r || !e) return '0;
    return s ? b : a;
  endfunction

  function automatic logic [W-1:0] m_selected();
    edge_t l;
    if (hist.size() == 0) return '0;
    l = hist[hist.size()-1];
    return mux_now(1'b0, l.e, l.sel, l.a, l.b);
  endfunction

  function automatic logic m_valid();
    if (hist.size() == 0) return 1'b0;
    return hist[hist.size()-1].e;
  endfunction

  // The source is the selector of the most recent enabled edge.
  function automatic logic m_src();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].e) return hist[i].sel;
    end
    return 1'b0;
  endfunction

  // A pulse needs two consecutive enabled edges with different selectors.
  function automatic logic m_pulse();
    edge_t l;
    edge_t p;
    if (hist.size() < 2) return 1'b0;
    l = hist[hist.size()-1];
    p = hist[hist.size()-2];
    return l.e && p.e && (l.sel != p.sel);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         e;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sel;
    logic         exp_valid;
    logic         exp_src;
    logic         exp_pulse;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic e, input logic s,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] xs, input logic xv,
                              input logic xsrc, input logic xp);
    vec_t v;
    v.rst = r; v.e = e; v.sel = s; v.a = a; v.b = b;
    v.exp_sel = xs; v.exp_valid = xv; v.exp_src = xsrc; v.exp_pulse = xp;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    rst_s = r;
    e_s   = e;
    sel_s = s;
    a_s   = a;
    b_s   = b;
  endtask

  task automatic check_status(input string tag, input logic xv, input logic xsrc, input logic xp);
    check({tag, "_valid_r"}, W'(if_r.selected_valid), W'(xv));
    check({tag, "_src_r"},   W'(if_r.active_src),     W'(xsrc));
    check({tag, "_pulse_r"}, W'(if_r.switch_pulse),   W'(xp));
    check({tag, "_valid_c"}, W'(if_c.selected_valid), W'(xv));
    check({tag, "_src_c"},   W'(if_c.active_src),     W'(xsrc));
    check({tag, "_pulse_c"}, W'(if_c.switch_pulse),   W'(xp));
  endtask

  initial begin
    logic r;

    //            rst   e     sel   a      b      sel_exp v     src   pulse
    vecs[0]  = mk(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0); // pass A
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0); // A changes, no pulse
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1); // switch to B
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0); // pulse clears
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0); // disable
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0); // toggle while off
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0); // re-enable on A, no pulse
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1); // switch to B=0
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0); // E falls with selector change

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].e, vecs[i].sel, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("vec%0d_comb_sel", i), if_c.selected, vecs[i].exp_sel);
      @(negedge clk);
      check($sformatf("vec%0d_sel_r", i), if_r.selected, vecs[i].exp_sel);
      check_status($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_src, vecs[i].exp_pulse);
    end

    // Asynchronous reset in the middle of a cycle.
    drive(1'b0, 1'b1, 1'b1, 8'h11, 8'hA5);
    @(negedge clk);
    check("pre_async_sel_r", if_r.selected, 8'hA5);
    check_status("pre_async", 1'b1, 1'b1, 1'b0);
    #2;
    rst_s = 1'b1;
    #1;
    check("async_sel_r", if_r.selected, 8'h00);
    check("async_sel_c", if_c.selected, 8'h00);
    check_status("async", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_s = 1'b0;

    // Combinational mode: the output follows the inputs without a clock.
    drive(1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3);
    #1;
    check("comb_b", if_c.selected, 8'hC3);
    sel_s = 1'b0;
    #1;
    check("comb_a", if_c.selected, 8'h5A);
    rst_s = 1'b1;
    #1;
    check("comb_rst", if_c.selected, 8'h00);
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);

    // Randomised stimulus against the history-based model.
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 39) == 0);
      drive(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      #1;
      check("rand_comb_sel", if_c.selected, mux_now(rst_s, e_s, sel_s, a_s, b_s));
      @(negedge clk);
      check("rand_sel_r", if_r.selected, m_selected());
      check_status("rand", m_valid(), m_src(), m_pulse());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
